match_controller: RTL and testbench



---
 rtl/game_pkg.sv | 27 ++
 rtl/seg7_digit.sv | 11 +
 rtl/match_controller.sv | 112 +++++++++++
 tb/tb_match_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the tug-of-war match logic.
// Holds the match states, the score type and the seven-segment digit table.
package game_pkg;

    localparam int SCORE_W = 3;

    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        PLAY,
        PAUSE,
        OVER
    } match_state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a} for the digits 0..7.
    localparam logic [6:0] SEG_DIGIT [8] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000
    };

endpackage

// File: rtl/seg7_digit.sv
// Combinational decoder from a 3-bit score to an active-low seven-segment pattern.
module seg7_digit
    import game_pkg::*;
(
    input  logic [2:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_DIGIT[digit];

endmodule

// File: rtl/match_controller.sv
// Match sequencer: scores round wins, pauses the playfield between rounds and
// declares the first player to reach WIN_SCORE as champion.
module match_controller
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_win,
    input  logic       c_win,
    output logic       round_rst,
    output logic       play_en,
    output logic [2:0] player_score,
    output logic [2:0] comp_score,
    output logic       match_over,
    output logic       champion,
    output logic [6:0] HEX0,
    output logic [6:0] HEX5
);

    localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    match_state_t     state;
    logic [CNT_W-1:0] pause_cnt;
    logic             p_win_q;
    logic             c_win_q;
    logic             p_rise;
    logic             c_rise;
    logic             p_final;
    logic             c_final;

    assign p_rise  = p_win & ~p_win_q;
    assign c_rise  = c_win & ~c_win_q;
    assign p_final = (player_score == score_t'(WIN_SCORE - 1));
    assign c_final = (comp_score == score_t'(WIN_SCORE - 1));

    // NOTE: every register here uses <= so all state updates see the values
    // from before this edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= PLAY;
            pause_cnt    <= '0;
            p_win_q      <= 1'b0;
            c_win_q      <= 1'b0;
            player_score <= '0;
            comp_score   <= '0;
            round_rst    <= 1'b0;
            play_en      <= 1'b1;
            match_over   <= 1'b0;
            champion     <= 1'b0;
        end else begin
            // Edge-detect flops run in every state so a held level scores once.
            p_win_q <= p_win;
            c_win_q <= c_win;

            case (state)
                PLAY: begin
                    if (p_rise ^ c_rise) begin
                        if (p_rise) begin
                            player_score <= player_score + 1'b1;
                        end else begin
                            comp_score <= comp_score + 1'b1;
                        end
                        round_rst <= 1'b1;
                        play_en   <= 1'b0;
                        if ((p_rise && p_final) || (c_rise && c_final)) begin
                            state      <= OVER;
                            match_over <= 1'b1;
                            champion   <= c_rise;
                        end else begin
                            state     <= PAUSE;
                            pause_cnt <= CNT_W'(PAUSE_CYCLES - 1);
                        end
                    end
                end

                PAUSE: begin
                    if (pause_cnt == '0) begin
                        state     <= PLAY;
                        round_rst <= 1'b0;
                        play_en   <= 1'b1;
                    end else begin
                        pause_cnt <= pause_cnt - 1'b1;
                    end
                end

                OVER: begin
                    // Frozen until reset.
                end

                default: begin
                    state     <= PLAY;
                    round_rst <= 1'b0;
                    play_en   <= 1'b1;
                end
            endcase
        end
    end

    seg7_digit u_hex0 (
        .digit (player_score),
        .seg   (HEX0)
    );

    seg7_digit u_hex5 (
        .digit (comp_score),
        .seg   (HEX5)
    );

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios followed by
// random win levels and resets, compared against a behavioural match model.
module tb_match_controller;

    localparam int WIN   = 5;
    localparam int PAUSE = 4;

    localparam logic [6:0] HEX_REF [8] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
    };

    logic       clk = 1'b0;
    logic       reset;
    logic       p_win;
    logic       c_win;
    logic       round_rst;
    logic       play_en;
    logic [2:0] player_score;
    logic [2:0] comp_score;
    logic       match_over;
    logic       champion;
    logic [6:0] HEX0;
    logic [6:0] HEX5;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: points, remaining pause cycles, match-over flag.
    int m_ps;
    int m_cs;
    int m_pause_left;
    bit m_over;
    bit m_champ;
    bit m_prev_p;
    bit m_prev_c;

    match_controller #(
        .WIN_SCORE    (WIN),
        .PAUSE_CYCLES (PAUSE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .p_win        (p_win),
        .c_win        (c_win),
        .round_rst    (round_rst),
        .play_en      (play_en),
        .player_score (player_score),
        .comp_score   (comp_score),
        .match_over   (match_over),
        .champion     (champion),
        .HEX0         (HEX0),
        .HEX5         (HEX5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise_p;
        bit rise_c;
        if (reset) begin
            m_ps = 0; m_cs = 0; m_pause_left = 0;
            m_over = 0; m_champ = 0; m_prev_p = 0; m_prev_c = 0;
        end else begin
            rise_p   = p_win && !m_prev_p;
            rise_c   = c_win && !m_prev_c;
            m_prev_p = p_win;
            m_prev_c = c_win;
            if (m_over) begin
                // match finished: nothing changes
            end else if (m_pause_left > 0) begin
                m_pause_left--;
            end else if (rise_p != rise_c) begin
                if (rise_p) m_ps++; else m_cs++;
                if (m_ps == WIN || m_cs == WIN) begin
                    m_over  = 1;
                    m_champ = rise_c;
                end else begin
                    m_pause_left = PAUSE;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit exp_rst;
        exp_rst = m_over || (m_pause_left > 0);
        check("player_score", 32'(player_score), 32'(m_ps));
        check("comp_score",   32'(comp_score),   32'(m_cs));
        check("round_rst",    32'(round_rst),    32'(exp_rst));
        check("play_en",      32'(play_en),      32'(!exp_rst));
        check("match_over",   32'(match_over),   32'(m_over));
        if (m_over) check("champion", 32'(champion), 32'(m_champ));
        check("HEX0", 32'(HEX0), 32'(HEX_REF[m_ps]));
        check("HEX5", 32'(HEX5), 32'(HEX_REF[m_cs]));
    endtask

    task automatic tick(input bit p, input bit c, input bit r);
        p_win = p;
        c_win = c;
        reset = r;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        p_win = 1'b0;
        c_win = 1'b0;
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("reset_champion", 32'(champion), 32'd0);

        // Idle after reset.
        idle(10);

        // Single player pulse: score, 4-cycle pause, resume.
        tick(1'b1, 1'b0, 1'b0);
        idle(7);

        // Held computer level scores exactly once.
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0);
        idle(6);

        // Simultaneous rises: no point.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        idle(3);

        // Fresh match: five player points win it.
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < WIN; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            idle(PAUSE + 1);
        end
        check("champion_player", 32'(champion), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        idle(3);
        tick(1'b0, 1'b0, 1'b1);
        check("post_over_reset_champion", 32'(champion), 32'd0);
        idle(2);

        // Computer pulse during a pause, then reset on the second pause cycle.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        idle(4);

        // Random levels and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit np;
            bit nc;
            bit nr;
            np = ($urandom_range(0, 5) == 0) ? !p_win : p_win;
            nc = ($urandom_range(0, 5) == 0) ? !c_win : c_win;
            nr = ($urandom_range(0, 299) == 0);
            tick(np, nc, nr);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
